// File: rtl/als_spi_reader_pkg.sv
// ---------------------------------------------------------------------------
// als_pkg
// Shared definitions for the ambient-light sensor serial reader: the frame
// FSM state type, the fixed frame layout of the sensor's 8-bit ADC and a
// helper that decides whether a received frame carries a valid sample.
// ---------------------------------------------------------------------------
package als_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    DONE
  } state_t;

  localparam int FRAME_BITS = 16;
  localparam int LEAD_BITS  = 3;
  localparam int DATA_MSB   = 11;
  localparam int DATA_LSB   = 4;

  // A frame is accepted only when every leading bit reads back as zero.
  function automatic logic frame_ok(input logic [LEAD_BITS-1:0] lead);
    return (lead == '0);
  endfunction

endpackage

// File: rtl/als_spi_reader_if.sv
// ---------------------------------------------------------------------------
// als_spi_reader_if
// Bundles the sensor link (ncs, scl, sda) with the sample output side
// (data, data_valid, frame_err).
//   master : the reader - drives ncs/scl and the sample outputs, reads sda
//   slave  : sensor + downstream consumer - drives sda, observes the rest
// ---------------------------------------------------------------------------
interface als_spi_reader_if;

  logic       ncs;
  logic       scl;
  logic       sda;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;

  modport master (
    output ncs,
    output scl,
    output data,
    output data_valid,
    output frame_err,
    input  sda
  );

  modport slave (
    input  ncs,
    input  scl,
    input  data,
    input  data_valid,
    input  frame_err,
    output sda
  );

endinterface

// File: rtl/als_spi_reader_sync.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Generic 1-bit two-flop synchronizer for asynchronous input pins.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, both flops clear to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/als_spi_reader.sv
// ---------------------------------------------------------------------------
// als_spi_reader
// Runs the read-only 3-wire serial link of the ambient-light sensor ADC.
// Free-running frames: ncs high for GAP_CYCLES, ncs low with scl high for
// CLK_DIV, 16 scl periods of 2*CLK_DIV, then one DONE cycle in which the
// captured frame is checked. A good frame updates data and pulses
// data_valid; a bad frame leaves data alone and pulses frame_err.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : master side of als_spi_reader_if (ncs, scl, sda, data,
//           data_valid, frame_err)
// Parameters:
//   CLK_DIV    : clk cycles per scl half-period (>= 4)
//   GAP_CYCLES : clk cycles with ncs high between frames (>= 1)
// ---------------------------------------------------------------------------
module als_spi_reader
  import als_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int GAP_CYCLES = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  als_spi_reader_if.master bus
);

  localparam int HC_W  = $clog2(CLK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

  state_t                  state;
  logic [HC_W-1:0]         hc;
  logic [GAP_W-1:0]        gap_cnt;
  logic [3:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   shreg;
  logic                    ncs_r;
  logic                    scl_r;
  logic [7:0]              data_r;
  logic                    dv_r;
  logic                    fe_r;
  logic                    sda_s;

  sync_2ff u_sda_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.sda),
    .q     (sda_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      hc      <= '0;
      gap_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      ncs_r   <= 1'b1;
      scl_r   <= 1'b1;
      data_r  <= '0;
      dv_r    <= 1'b0;
      fe_r    <= 1'b0;
    end else begin
      dv_r <= 1'b0;
      fe_r <= 1'b0;
      case (state)
        IDLE: begin
          ncs_r <= 1'b1;
          scl_r <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            hc      <= '0;
            ncs_r   <= 1'b0;
            state   <= SETUP;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        SETUP: begin
          if (hc == HC_LAST) begin
            hc      <= '0;
            bit_cnt <= '0;
            scl_r   <= 1'b0;
            state   <= SHIFT;
          end else begin
            hc <= hc + 1'b1;
          end
        end

        // scl_r itself tells which half of the bit period is running.
        SHIFT: begin
          if (hc == HC_LAST) begin
            hc <= '0;
            if (!scl_r) begin
              // Rising scl edge: the sensor has held this bit for CLK_DIV cycles.
              scl_r <= 1'b1;
              shreg <= {shreg[FRAME_BITS-2:0], sda_s};
            end else if (bit_cnt == BIT_LAST) begin
              ncs_r <= 1'b1;
              state <= DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              scl_r   <= 1'b0;
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end

        DONE: begin
          ncs_r <= 1'b1;
          scl_r <= 1'b1;
          state <= IDLE;
          if (frame_ok(shreg[FRAME_BITS-1 -: LEAD_BITS])) begin
            data_r <= shreg[DATA_MSB:DATA_LSB];
            dv_r   <= 1'b1;
          end else begin
            fe_r <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ncs        = ncs_r;
  assign bus.scl        = scl_r;
  assign bus.data       = data_r;
  assign bus.data_valid = dv_r;
  assign bus.frame_err  = fe_r;

endmodule

// File: tb/tb_als_spi_reader.sv
// ---------------------------------------------------------------------------
// tb_als_spi_reader
// Drives als_spi_reader with CLK_DIV=4, GAP_CYCLES=10 against a sensor
// model that presents frame bits a jittered delay after each scl fall.
// A timing model derived from the frame schedule predicts ncs, scl, data
// and the pulse outputs for every cycle; literal expectations pin it.
// ---------------------------------------------------------------------------
module tb_als_spi_reader;

  localparam int CLK_DIV = 4;
  localparam int GAP     = 10;
  localparam int PER     = GAP + CLK_DIV + 32 * CLK_DIV + 1;  // 143
  localparam int LOWLEN  = CLK_DIV + 32 * CLK_DIV;            // 132
  localparam int NFR     = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int errors = 0;
  int checks = 0;

  // Frames in the order the sensor sends them; index 5 is cut by reset.
  logic [15:0] seq [NFR] = '{16'h05A0, 16'h0000, 16'h0FF0, 16'h0810,
                             16'h2FF0, 16'h0550, 16'h0C30};

  als_spi_reader_if bus ();

  als_spi_reader #(
    .CLK_DIV    (CLK_DIV),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Rising clk edges since reset release.
  int e = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) e <= 0;
    else        e <= e + 1;
  end

  // Sensor: each scl fall presents the next frame bit, MSB first.
  initial begin : sensor
    int          tx;
    int          bi;
    int          d;
    logic [15:0] fr;
    tx = 0;
    bus.sda = 1'b0;
    forever begin
      @(negedge bus.ncs);
      fr = (tx < NFR) ? seq[tx] : 16'h0000;
      tx++;
      bi = 15;
      while (bi >= 0) begin
        @(negedge bus.scl or posedge bus.ncs);
        if (bus.ncs) break;
        d = 1 + int'($urandom_range(0, 18));  // 1..19 time units, clk period 10
        #(d);
        if (bus.ncs) break;
        bus.sda = fr[bi];
        bi--;
      end
    end
  end

  // Cycle model: frame k starts at edge GAP + k*PER, result pulse at (k+1)*PER.
  initial begin : compare
    int          o;
    int          gp;
    logic [15:0] cur;
    logic [7:0]  m_data;
    logic        e_ncs, e_scl, e_dv, e_fe;
    gp = 0;
    cur = '0;
    m_data = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_data = 8'h00;
        chk("rst_ncs",  bus.ncs,        32'd1);
        chk("rst_scl",  bus.scl,        32'd1);
        chk("rst_data", bus.data,       32'd0);
        chk("rst_dv",   bus.data_valid, 32'd0);
        chk("rst_fe",   bus.frame_err,  32'd0);
      end else begin
        e_ncs = 1'b1;
        e_scl = 1'b1;
        e_dv  = 1'b0;
        e_fe  = 1'b0;
        if (e >= GAP) begin
          o = (e - GAP) % PER;
          if (o == 0) begin
            cur = (gp < NFR) ? seq[gp] : 16'h0000;
            gp++;
          end
          if (o < LOWLEN) begin
            e_ncs = 1'b0;
            if (o >= CLK_DIV && ((o - CLK_DIV) % (2 * CLK_DIV)) < CLK_DIV) e_scl = 1'b0;
          end
        end
        if (e > 0 && (e % PER) == 0) begin
          if (cur[15:13] == 3'b000) begin
            e_dv   = 1'b1;
            m_data = cur[11:4];
          end else begin
            e_fe = 1'b1;
          end
        end
        chk("ncs",        bus.ncs,        32'(e_ncs));
        chk("scl",        bus.scl,        32'(e_scl));
        chk("data",       bus.data,       32'(m_data));
        chk("data_valid", bus.data_valid, 32'(e_dv));
        chk("frame_err",  bus.frame_err,  32'(e_fe));
      end
    end
  end

  // Observed pulse counts, frame shape and scl phase lengths.
  int   dv_cnt = 0;
  int   fe_cnt = 0;
  int   dv_at[$];
  int   low_run = 0;
  int   last_low = 0;
  int   falls = 0;
  int   last_falls = 0;
  int   run = 0;
  logic p_scl = 1'b1;
  logic p_ncs = 1'b1;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_scl   = 1'b1;
        p_ncs   = 1'b1;
        run     = 0;
        falls   = 0;
        low_run = 0;
      end else begin
        if (bus.data_valid) begin
          dv_cnt++;
          dv_at.push_back(e);
        end
        if (bus.frame_err) fe_cnt++;
        if (!bus.ncs) begin
          if (p_ncs) begin
            low_run = 0;
            falls   = 0;
          end
          low_run++;
        end else if (!p_ncs) begin
          last_low   = low_run;
          last_falls = falls;
        end
        if (bus.scl == p_scl) begin
          run++;
        end else begin
          if (!p_scl)        chk("scl_low_phase",  run, CLK_DIV);
          else if (falls > 0) chk("scl_high_phase", run, CLK_DIV);
          if (!bus.scl && !bus.ncs) falls++;
          run = 1;
        end
        p_scl = bus.scl;
        p_ncs = bus.ncs;
      end
    end
  end

  task automatic wait_cnt(input int which, input int target, input int budget, input string name);
    int n;
    n = 0;
    while (((which == 0) ? dv_cnt : fe_cnt) < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(name, 32'(((which == 0) ? dv_cnt : fe_cnt) >= target), 32'd1);
  endtask

  initial begin : main
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("lit_reset_data", bus.data, 32'h00);
    chk("lit_reset_ncs",  bus.ncs,  32'd1);
    rst_n = 1'b1;

    wait_cnt(0, 1, 400, "wait_dv1");
    chk("lit_data_5a",      bus.data,   32'h5A);
    chk("lit_ncs_low_len",  last_low,   32'd132);
    chk("lit_scl_falls",    last_falls, 32'd16);
    if (dv_at.size() >= 1) chk("lit_first_dv_edge", dv_at[0], 32'd143);

    wait_cnt(0, 2, 300, "wait_dv2");
    chk("lit_data_00", bus.data, 32'h00);
    wait_cnt(0, 3, 300, "wait_dv3");
    chk("lit_data_ff", bus.data, 32'hFF);
    wait_cnt(0, 4, 300, "wait_dv4");
    chk("lit_data_81", bus.data, 32'h81);
    if (dv_at.size() >= 4) begin
      chk("lit_period_1", dv_at[1] - dv_at[0], 32'd143);
      chk("lit_period_2", dv_at[2] - dv_at[1], 32'd143);
      chk("lit_period_3", dv_at[3] - dv_at[2], 32'd143);
    end

    wait_cnt(1, 1, 300, "wait_fe1");
    chk("lit_err_keeps_data", bus.data, 32'h81);
    chk("lit_no_dv_on_err",   dv_cnt,   32'd4);
    chk("lit_fe_edge",        e,        32'd715);

    // Reach the low phase of bit 7 in the sixth frame, then reset.
    n = 0;
    while (e != GAP + 5 * PER + 60 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #3;
    chk("pre_abort_ncs", bus.ncs, 32'd0);
    chk("pre_abort_scl", bus.scl, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("abort_ncs", bus.ncs, 32'd1);
    chk("abort_scl", bus.scl, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;

    n = 0;
    while (bus.ncs && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("lit_gap_after_reset", e, 32'd10);

    wait_cnt(0, 5, 400, "wait_dv5");
    chk("lit_data_c3",        bus.data, 32'hC3);
    chk("lit_fe_total",       fe_cnt,   32'd1);
    chk("lit_dv_after_reset", e,        32'd143);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

endmodule

// File: doc/als_spi_reader.md
# als_spi_reader

Front-end stage of the light-to-PWM chain. It runs the serial interface of the ambient-light sensor's 8-bit ADC, which is a read-only, SPI-like 3-wire link (active-low chip select, serial clock, serial data out). Each free-running conversion frame produces one 8-bit intensity sample and a one-cycle valid strobe. The sample feeds the averaging filter, which in turn drives the colour map and the three PWM channels.

## Interface
- CLK_DIV, 25: `clk` cycles per SCL half-period; legal range ≥4 (default gives 2 MHz SCL at 100 MHz).
- GAP_CYCLES, 100: `clk` cycles with `ncs` high between frames; legal range ≥1.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ncs`  out  1  sensor chip select, active low.
- `scl`  out  1  sensor serial clock; idles high.
- `sda`  in  1  sensor serial data; asynchronous to `clk`.
- `data`  out  8  last good sample; holds its value between frames.
- `data_valid`  out  1  one-cycle pulse when `data` is updated.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected.

## Operation
- Reset values: `ncs`=1, `scl`=1, `data`=0x00, `data_valid`=0, `frame_err`=0, FSM=IDLE, all counters 0.
- `sda` passes through a 2-flop synchronizer before any use.
- Frame format: 16 bits, MSB first, made up of 3 leading zeros, then D7..D0, then 4 trailing zeros. The sensor changes `sda` after each SCL falling edge. The block samples on each SCL rising edge.
- FSM states:
  - IDLE: `ncs`=1, `scl`=1, counts GAP_CYCLES cycles, then goes to SETUP.
  - SETUP: `ncs`=0, `scl`=1 for CLK_DIV cycles, then goes to SHIFT.
  - SHIFT: runs 16 bit periods. Each period is `scl`=0 for CLK_DIV cycles, then `scl`=1 for CLK_DIV cycles.
    - The synchronized `sda` is shifted into a 16-bit register on the same clock edge that drives `scl` 0→1.
    - After the high phase of bit 15, go to DONE.
  - DONE: one cycle with `ncs`=1 and `scl`=1, then go to IDLE.
- Frame check, evaluated on the DONE cycle:
  - Leading 3 bits (frame[15:13]) all 0: `data` ← frame[11:4] and `data_valid` pulses.
  - Otherwise: `data` is unchanged and `frame_err` pulses.
  - Trailing bits are ignored.
- `data_valid` and `frame_err` are never high in the same cycle.
- Both pulse outputs are registered. Each is high for exactly the one cycle after the DONE edge.
- Reset mid-frame:
  - `ncs` and `scl` return high asynchronously; the partial shift is discarded; no pulse is produced.
  - After `rst_n` rises, the block starts from IDLE with a full gap.
- Arithmetic and widths:
  - Half-period counter width is $clog2(CLK_DIV).
  - Gap counter width is $clog2(GAP_CYCLES+1).
  - Bit counter is 4 bits and covers 0..15 with no wrap inside a frame.

## Timing
- Frame period: GAP_CYCLES + CLK_DIV + 32·CLK_DIV + 1 `clk` cycles.
- `ncs` fall to first `scl` fall: CLK_DIV cycles.
- Last `scl` rise to `ncs` rise: CLK_DIV cycles (the final high phase).
- SCL duty cycle is exactly 50%; there are exactly 16 SCL falling edges per frame.
- Latency from the 16th sampling edge to `data_valid`: CLK_DIV + 1 cycles.
- Sampling margin: the sample is taken CLK_DIV cycles after the falling edge, minus 2 cycles of synchronizer delay. CLK_DIV ≥ 4 keeps ≥2 cycles of margin. This margin must cover the sensor's access time.
- `data` is stable for the whole frame period; the downstream filter may sample it on `data_valid` or at any other time.

## Structure
- Shared package `als_pkg`, containing:
  - state enum {IDLE, SETUP, SHIFT, DONE};
  - FRAME_BITS=16, LEAD_BITS=3, DATA_MSB=11, DATA_LSB=4.
- Sub-module `sync_2ff`: a generic 1-bit two-flop synchronizer with async active-low reset to 0. It is reusable by other input pins.
- Everything else (FSM, counters, shift register, check logic) lives in `als_spi_reader`.

## Test plan
- CLK_DIV=4, GAP_CYCLES=10; sensor model returns frame 0x05A0 (data 0x5A) → `data`=0x5A, `data_valid` high for 1 cycle, `ncs` low for 132 cycles, frame period 143 cycles, 16 SCL falls with an 8-cycle period.
- Back-to-back frames with data 0x00, then 0xFF, then 0x81 → three `data_valid` pulses exactly 143 cycles apart; `data` follows 0x00, 0xFF, 0x81.
- Frame 0x2FF0 (a leading bit set) → `frame_err` pulses once; `data` keeps the previous value 0x81; no `data_valid`.
- Assert `rst_n` low during bit 7 of SHIFT → `ncs` and `scl` go high in the same cycle; no pulse is produced. After release, the first `ncs` fall comes 10 cycles later and the full next frame decodes correctly.
- `sda` transitions driven 1 cycle after each SCL fall, with random jitter of ±1 cycle → all samples are decoded correctly; SCL high and low phases are each exactly CLK_DIV cycles.
- Reset only, no frames yet → `data`=0x00 and both pulse outputs stay 0 until the first DONE.
